// File: rtl/bcd_display_scan_if.sv
// Load/status handshake between the timer top level and the display stage.
`timescale 1ns/1ps
interface bcd_display_scan_if;
  logic        load;
  logic [15:0] value;
  logic [3:0]  prefix;
  logic        busy;
  logic        done;

  modport master (output load, value, prefix, input busy, done);
  modport slave  (input load, value, prefix, output busy, done);
endinterface

// File: rtl/bcd_display_scan.sv
// Sequential binary-to-BCD converter feeding an 8-digit multiplexed 7-segment scanner.
// Optional macro BCD_LEADING_ZERO_BLANK_EN blanks leading zero digits d4..d1.
`timescale 1ns/1ps
module bcd_display_scan #(
  parameter int SCAN_DIV = 100000
) (
  input  logic                clock,
  input  logic                reset,
  bcd_display_scan_if.slave   req,
  output logic [7:0]          an,
  output logic [7:0]          dec_cat
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

  state_e            state_q, state_d;
  logic [15:0]       bin_q;
  logic [19:0]       bcd_q, bcd_adj_d;
  logic [3:0]        cnt_q;
  logic [3:0]        stage_q;
  logic [4:0][3:0]   dig_q;
  logic [3:0]        prefix_q;
  logic [4:0]        blank_q, blank_d;
  logic              done_q;
  logic              busy, accept, shift_en, commit;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        an_q, an_d, cat_q, cat_d;
  logic              tick;

  function automatic logic [7:0] seg7(input logic [3:0] h);
    case (h)
      4'h0: seg7 = 8'h03;  4'h1: seg7 = 8'h9F;  4'h2: seg7 = 8'h25;  4'h3: seg7 = 8'h0D;
      4'h4: seg7 = 8'h99;  4'h5: seg7 = 8'h49;  4'h6: seg7 = 8'h41;  4'h7: seg7 = 8'h1F;
      4'h8: seg7 = 8'h01;  4'h9: seg7 = 8'h09;  4'hA: seg7 = 8'h11;  4'hB: seg7 = 8'hC1;
      4'hC: seg7 = 8'h63;  4'hD: seg7 = 8'h85;  4'hE: seg7 = 8'h61;  default: seg7 = 8'h71;
    endcase
  endfunction

  // ---------------- converter FSM ----------------
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req.load) state_d = SHIFT;
      SHIFT:   if (cnt_q == 4'd15) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    accept   = (state_q == IDLE) && req.load;
    shift_en = (state_q == SHIFT);
    commit   = (state_q == COMMIT);
  end

  // Add-3 correction on every nibble before the shift
  always_comb begin
    bcd_adj_d = bcd_q;
    for (int i = 0; i < 5; i++)
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj_d[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
  end

`ifdef BCD_LEADING_ZERO_BLANK_EN
  always_comb begin
    blank_d    = '0;
    blank_d[4] = (bcd_q[19:16] == 4'd0);
    for (int i = 3; i >= 1; i--)
      blank_d[i] = blank_d[i+1] && (bcd_q[i*4 +: 4] == 4'd0);
  end
  // Reset mask matches all-zero digits so the display agrees with a committed 0
  localparam logic [4:0] BLANK_RST = 5'b11110;
`else
  always_comb blank_d = '0;
  localparam logic [4:0] BLANK_RST = 5'b00000;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      stage_q  <= '0;
      dig_q    <= '0;
      prefix_q <= '0;
      blank_q  <= BLANK_RST;
      done_q   <= 1'b0;
    end else begin
      done_q <= commit;
      if (accept) begin
        bin_q   <= req.value;
        stage_q <= req.prefix;
        bcd_q   <= '0;
        cnt_q   <= '0;
      end else if (shift_en) begin
        {bcd_q, bin_q} <= {bcd_adj_d[18:0], bin_q, 1'b0};
        cnt_q          <= cnt_q + 4'd1;
      end
      if (commit) begin
        dig_q    <= bcd_q;
        prefix_q <= stage_q;
        blank_q  <= blank_d;
      end
    end
  end

  assign req.busy = busy;
  assign req.done = done_q;

  // ---------------- scanner ----------------
  always_comb begin
    tick  = (div_q == DIV_MAX);
    div_d = tick ? '0 : div_q + 1'b1;
    idx_d = tick ? idx_q + 3'd1 : idx_q;
    an_d  = ~(8'b1 << idx_q);
    cat_d = 8'hFF;
    if (idx_q <= 3'd4) begin
      if (!blank_q[idx_q]) cat_d = seg7(dig_q[idx_q]);
    end else if (idx_q == 3'd7) begin
      cat_d = seg7(prefix_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q <= '0;
      idx_q <= '0;
      an_q  <= 8'hFF;
      cat_q <= 8'hFF;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      cat_q <= cat_d;
    end
  end

  assign an      = an_q;
  assign dec_cat = cat_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Randomized self-checking bench for bcd_display_scan against an arithmetic display model.
`timescale 1ns/1ps
module tb_bcd_display_scan;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  bcd_display_scan_if bus ();
  bcd_display_scan_if bus1 ();
  logic [7:0] an, cat, an1, cat1;

  bcd_display_scan #(.SCAN_DIV(4)) dut (
    .clock(clock), .reset(reset), .req(bus), .an(an), .dec_cat(cat));
  bcd_display_scan #(.SCAN_DIV(1)) dut1 (
    .clock(clock), .reset(reset), .req(bus1), .an(an1), .dec_cat(cat1));

  int errors = 0;
  int checks = 0;
  int since_rst = 0;
  int mdl_val = 0;
  int mdl_pfx = 0;
  logic [7:0] obs [8];

  const logic [7:0] SEG [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                 8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  always @(posedge clock) since_rst <= reset ? 0 : since_rst + 1;

  // Expected segment pattern at a scan position for a committed decimal value
  function automatic logic [7:0] exp_cat(input int pos, input int val, input int pfx);
    int p10;
    if (pos == 5 || pos == 6) return 8'hFF;
    if (pos == 7) return SEG[pfx];
    p10 = 10 ** pos;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    if (pos > 0 && val < p10) return 8'hFF;
`endif
    return SEG[(val / p10) % 10];
  endfunction

  function automatic logic [7:0] exp_an(input int pos);
    logic [7:0] one;
    one = 8'd1;
    return ~(one << pos);
  endfunction

  // Record the last dec_cat seen at every scan position over ncyc cycles
  task automatic capture(input int ncyc);
    for (int p = 0; p < 8; p++) obs[p] = 8'hxx;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clock);
      for (int p = 0; p < 8; p++) if (an === exp_an(p)) obs[p] = cat;
    end
  endtask

  // Issue a load, optionally a second one second_at+1 edges later; observe 30 cycles
  task automatic run_load(input logic [15:0] v, input logic [3:0] pf, input int second_at,
                          input logic [15:0] v2, output int lat, output int nbusy, output int ndone);
    lat = -1; nbusy = 0; ndone = 0;
    bus.value = v; bus.prefix = pf; bus.load = 1'b1;
    @(negedge clock);
    bus.load = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clock);
      if (bus.busy === 1'b1) nbusy++;
      if (bus.done === 1'b1) begin ndone++; if (lat < 0) lat = i; end
      if (i == second_at) begin bus.value = v2; bus.load = 1'b1; end
      else bus.load = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.load = 1'b1; bus.value = 16'd4321; bus.prefix = 4'hA;
    bus1.load = 1'b0; bus1.value = '0; bus1.prefix = '0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (an !== 8'hFF) begin errors++; $display("FAIL reset_an got=%h exp=ff", an); end
    checks++; if (cat !== 8'hFF) begin errors++; $display("FAIL reset_cat got=%h exp=ff", cat); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    reset = 1'b0; bus.load = 1'b0;
    @(negedge clock);
    checks++; if (an !== 8'hFE) begin errors++; $display("FAIL release_an got=%h exp=fe", an); end
    checks++; if (cat !== 8'h03) begin errors++; $display("FAIL release_cat got=%h exp=03", cat); end
    mdl_val = 0; mdl_pfx = 0;
  endtask

  task automatic test_convert_scan();
    int lat, nb, nd, idx;
    run_load(16'd12345, 4'hF, -1, 16'd0, lat, nb, nd);
    mdl_val = 12345; mdl_pfx = 15;
    checks++; if (lat !== 17) begin errors++; $display("FAIL conv_latency got=%0d exp=17", lat); end
    checks++; if (nb !== 17) begin errors++; $display("FAIL conv_busy_cycles got=%0d exp=17", nb); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL conv_done_pulses got=%0d exp=1", nd); end
    // 40 cycles of the free-running scan include a 7->0 wrap
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      idx = ((since_rst - 1) / 4) % 8;
      checks++;
      if (an !== exp_an(idx)) begin errors++; $display("FAIL scan_an t=%0d got=%h exp=%h", since_rst, an, exp_an(idx)); end
      checks++;
      if (cat !== exp_cat(idx, mdl_val, mdl_pfx)) begin
        errors++; $display("FAIL scan_cat idx=%0d got=%h exp=%h", idx, cat, exp_cat(idx, mdl_val, mdl_pfx));
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, nb, nd;
    run_load(16'd65535, 4'h3, 2, 16'd1, lat, nb, nd);
    mdl_val = 65535; mdl_pfx = 3;
    checks++; if (nd !== 1) begin errors++; $display("FAIL b2b_done_pulses got=%0d exp=1", nd); end
    checks++; if (lat !== 17) begin errors++; $display("FAIL b2b_latency got=%0d exp=17", lat); end
    capture(40);
    for (int p = 0; p < 8; p++) begin
      checks++;
      if (obs[p] !== exp_cat(p, mdl_val, mdl_pfx)) begin
        errors++; $display("FAIL b2b_digit pos=%0d got=%h exp=%h", p, obs[p], exp_cat(p, mdl_val, mdl_pfx));
      end
    end
  endtask

  task automatic test_zero_blank();
    int lat, nb, nd;
    int vals [2] = '{0, 100};
    for (int k = 0; k < 2; k++) begin
      run_load(16'(vals[k]), 4'h0, -1, 16'd0, lat, nb, nd);
      mdl_val = vals[k]; mdl_pfx = 0;
      checks++; if (lat !== 17) begin errors++; $display("FAIL zero_latency v=%0d got=%0d exp=17", vals[k], lat); end
      capture(40);
      for (int p = 0; p < 8; p++) begin
        checks++;
        if (obs[p] !== exp_cat(p, mdl_val, mdl_pfx)) begin
          errors++; $display("FAIL zero_digit v=%0d pos=%0d got=%h exp=%h", vals[k], p, obs[p], exp_cat(p, mdl_val, mdl_pfx));
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    int nd, lat, nb;
    nd = 0;
    bus.value = 16'd999; bus.prefix = 4'h9; bus.load = 1'b1;
    @(negedge clock);
    bus.load = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clock);
      if (bus.done === 1'b1) nd++;
      if (i == 7) reset = 1'b1;
      if (i == 9) reset = 1'b0;
    end
    mdl_val = 0; mdl_pfx = 0;
    checks++; if (nd !== 0) begin errors++; $display("FAIL abort_done_pulses got=%0d exp=0", nd); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    capture(40);
    for (int p = 0; p < 8; p++) begin
      checks++;
      if (obs[p] !== exp_cat(p, mdl_val, mdl_pfx)) begin
        errors++; $display("FAIL abort_digit pos=%0d got=%h exp=%h", p, obs[p], exp_cat(p, mdl_val, mdl_pfx));
      end
    end
    run_load(16'd7, 4'h2, -1, 16'd0, lat, nb, nd);
    mdl_val = 7; mdl_pfx = 2;
    checks++; if (lat !== 17) begin errors++; $display("FAIL after_abort_latency got=%0d exp=17", lat); end
    capture(40);
    checks++; if (obs[0] !== 8'h1F) begin errors++; $display("FAIL after_abort_d0 got=%h exp=1f", obs[0]); end
    for (int p = 1; p < 8; p++) begin
      checks++;
      if (obs[p] !== exp_cat(p, mdl_val, mdl_pfx)) begin
        errors++; $display("FAIL after_abort_digit pos=%0d got=%h exp=%h", p, obs[p], exp_cat(p, mdl_val, mdl_pfx));
      end
    end
  endtask

  task automatic test_scan_div1();
    int idx;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      idx = (since_rst - 1) % 8;
      checks++;
      if (an1 !== exp_an(idx)) begin errors++; $display("FAIL div1_an t=%0d got=%h exp=%h", since_rst, an1, exp_an(idx)); end
      checks++;
      if (cat1 !== exp_cat(idx, 0, 0)) begin errors++; $display("FAIL div1_cat idx=%0d got=%h exp=%h", idx, cat1, exp_cat(idx, 0, 0)); end
    end
  endtask

  task automatic test_random();
    int lat, nb, nd, v, pf;
    for (int n = 0; n < 8; n++) begin
      v  = (n == 0) ? 9 : (n == 1) ? 10 : int'($urandom_range(0, 65535));
      pf = int'($urandom_range(0, 15));
      run_load(16'(v), 4'(pf), -1, 16'd0, lat, nb, nd);
      mdl_val = v; mdl_pfx = pf;
      checks++; if (lat !== 17 || nd !== 1) begin errors++; $display("FAIL rand_done v=%0d lat=%0d pulses=%0d exp=17/1", v, lat, nd); end
      capture(40);
      for (int p = 0; p < 8; p++) begin
        checks++;
        if (obs[p] !== exp_cat(p, mdl_val, mdl_pfx)) begin
          errors++; $display("FAIL rand_digit v=%0d pos=%0d got=%h exp=%h", v, p, obs[p], exp_cat(p, mdl_val, mdl_pfx));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_div1();
    test_convert_scan();
    test_back_to_back();
    test_zero_blank();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
- Downstream display stage of the Fibonacci/timer top level.
- Takes the 16-bit count value plus a 4-bit mode prefix.
- Converts the value to 5 BCD digits with a sequential double-dabble, one shift per clock.
- Time-multiplexes 8 common-anode 7-segment digits onto the an/dec_cat board pins.

Parameters:
- SCAN_DIV, 100000, clock cycles each digit stays lit (1 kHz per digit at 100 MHz); legal range >=1.

Ports:
- clock  in  1  system clock (100 MHz)
- reset  in  1  synchronous, active-high reset
- load  in  1  single-cycle request to capture value/prefix
- value  in  16  unsigned binary value to display (0..65535)
- prefix  in  4  hex code shown on digit 7 (mode indicator)
- busy  out  1  conversion in progress; load ignored while high
- done  out  1  one-cycle pulse when new digits are committed
- an  out  8  anode enables, active low, one-hot-zero
- dec_cat  out  8  segments, active low, {a,b,c,d,e,f,g,dp}

Behaviour:
- Clock is clock, reset is reset; single clock domain; reset is synchronous and active-high.
- Reset values:
  - an=8'hFF, dec_cat=8'hFF, busy=0, done=0.
  - Digit registers d0..d4=0; prefix register=0.
  - Scan index=0; divider=0.
  - Reset wins over a simultaneous load.
- Converter FSM, states IDLE, SHIFT, COMMIT:
  - IDLE: load=1 at edge k captures value into a 16-bit shift register and prefix into a staging register; BCD accumulator (20 bits) cleared; busy=1 from k+1; go to SHIFT.
  - SHIFT: 16 iterations at edges k+1..k+16. Each iteration adds 3 to every BCD nibble >=5, then shifts {bcd,bin} left by 1. 4-bit iteration counter.
  - COMMIT: at edge k+17, d4..d0 and the prefix register are written atomically; busy=0; done=1 for exactly one cycle; return to IDLE.
  - Load-to-done latency is 17 cycles.
  - load while busy=1 is dropped, not queued. load at the same edge done rises is also dropped.
  - A new load is accepted from the cycle after done.
  - reset mid-conversion aborts the conversion. Digits return to 0 and the partial result is discarded.
- Scanner (runs continuously, independent of FSM):
  - Divider counts 0..SCAN_DIV-1; its wrap is the tick. On a tick, index increments modulo 8 (7->0).
  - an and dec_cat are registered: an <= ~(8'b1 << index); dec_cat <= code(digit[index]).
  - First cycle after reset release: an=8'hFE, showing d0. The index advances every SCAN_DIV cycles.
- Digit mapping: index 0..4 = d0 (units)..d4 (ten-thousands); index 5,6 blank (8'hFF); index 7 = prefix as hex.
- dp always off (bit0 = 1).
- Segment codes, 0..F: 03,9F,25,0D,99,49,41,1F,01,09,11,C1,63,85,61,71 (hex).
- Committed digits appear on dec_cat at the next registered update of that index. No tearing: all 5 digits change at the same edge.

Optional Feature:
- BCD_LEADING_ZERO_BLANK_EN defined:
  - At COMMIT, a blank mask is computed: d4..d1 blank (dec_cat=8'hFF) when they and every higher digit are 0.
  - d0 is never blanked.
  - an still scans all 8 positions.
- Undefined: all five digits are always shown, including leading zeros.

Test Plan:
- Reset: hold reset 3 cycles with load=1 -> an=FF, dec_cat=FF, busy=0, done=0. Cycle after release: an=FE, dec_cat=03.
- SCAN_DIV=4, load value=12345, prefix=F:
  - busy high 17 cycles; done pulse 17 cycles after load.
  - Scan gives an FE/FD/FB/F7/EF/DF/BF/7F with dec_cat 49,99,0D,25,9F,FF,FF,71.
  - Index wraps 7->0 after 32 cycles.
- Load value=65535, then a second load value=1 three cycles later -> second load ignored; digits show 6,5,5,3,5; exactly one done pulse.
- Load value=0:
  - Without the macro -> digits 0..4 all 03.
  - With BCD_LEADING_ZERO_BLANK_EN -> digit0=03, digits 1..4=FF.
  - Then value=100 with the macro -> d0=03, d1=03, d2=9F, d3/d4=FF.
- Load value=999, assert reset at cycle k+8 -> no done pulse; digits all 0. After release, load value=7 -> d0=1F after 17 cycles.
- SCAN_DIV=1 -> an changes every cycle, full 8-digit cycle in 8 clocks, no skipped index.
